sal_bank_fsm: RTL and testbench
===============================

Name: sal_bank_fsm

Overview:
- Parametrised per-bank state machine for the DDR2 controller.
- Sits between the address decoder's per-bank request path and the command scheduler. Accepts one decoded request at a time and emits ACT/RD/WR/PRE command requests to the scheduler.
- Enforces the programmable tRCD, tRP and tRAS timings and supports open-page and close-page policy.
- Honours refresh requests by closing the bank and holding it idle.

Parameters:
- ROW_W, 14, row address width
- COL_W, 10, column address width
- ID_W, 4, request/transaction ID width
- TIMER_W, 5, width of timing config fields and internal counters
- PAGE_POLICY, 0, 0 = open page, 1 = close page

Ports:
- clk  in  1  controller clock
- rst  in  1  reset
- req_valid  in  1  decoded request valid
- req_ready  out  1  request buffer empty
- req_wr  in  1  1 = write, 0 = read
- req_row  in  ROW_W  target row
- req_col  in  COL_W  target column
- req_id  in  ID_W  transaction ID
- cfg_trcd  in  TIMER_W  ACT-to-RD/WR cycles
- cfg_trp  in  TIMER_W  PRE-to-ACT cycles
- cfg_tras  in  TIMER_W  ACT-to-PRE cycles
- cmd_valid  out  1  command presented to scheduler
- cmd_ready  in  1  scheduler grant
- cmd_type  out  2  0 PRE, 1 ACT, 2 RD, 3 WR
- cmd_row  out  ROW_W  row for ACT (buffered row otherwise)
- cmd_col  out  COL_W  column for RD/WR
- cmd_id  out  ID_W  ID for RD/WR
- ref_req  in  1  refresh pending (level)
- ref_ack  out  1  bank closed and parked for refresh
- bank_open  out  1  row currently open
- open_row  out  ROW_W  currently open row

Behaviour:
- Reset (interface, already decided): one clock, clk; reset rst is synchronous, active-high.
- Reset values: cmd_valid=0, cmd_type=0, cmd_row/col/id=0, req_ready=1, ref_ack=0, bank_open=0, open_row=0. All timers expired; state IDLE.
- Reset asserted mid-operation aborts any pending command and discards the buffer.
- Request buffer: single entry; req_ready = !buf_valid.
  - Load on req_valid && req_ready.
  - Clear on the RD/WR handshake. No same-cycle refill.
- Command handshake: transfer on cmd_valid && cmd_ready. Once cmd_valid is high, cmd_type, cmd_row, cmd_col and cmd_id stay stable until the handshake.
- States: IDLE (closed), ACT_WAIT, ACTIVE, PRE_WAIT.
- IDLE:
  - If buf_valid && !ref_req && tRP expired: present ACT(buf_row).
  - On handshake: go to ACT_WAIT, set open_row=buf_row, set bank_open=1, start tRCD and tRAS.
- ACT_WAIT: go to ACTIVE once tRCD expires.
- ACTIVE, priority order:
  - Buffered row hit: present RD/WR.
  - Buffered row miss: present PRE.
  - ref_req with empty buffer: present PRE.
  - PAGE_POLICY=1 with empty buffer: present PRE.
  - Otherwise idle.
  - PRE is never presented before tRAS expires.
  - On PRE handshake: set bank_open=0, start tRP, go to PRE_WAIT.
- PRE_WAIT: go to IDLE once tRP expires.
- Timing: for a handshake at cycle T with config value N, the dependent command is handshaken no earlier than T+max(N,1). A config value of 0 is treated as 1.
- ref_ack = 1 in IDLE when ref_req=1 and cmd_valid=0. No ACT is presented while ref_req=1. A buffered request waits until ref_req falls.
- Simultaneous events:
  - ref_req rising while an ACT is presented: the ACT completes first.
  - A request accepted in the same cycle as a PRE handshake is served after PRE_WAIT.
- Counter arithmetic: unsigned TIMER_W, saturating at 0, no wrap.

Decomposition:
- Package sal_ddr_pkg: cmd_type enum (PRE/ACT/RD/WR), bank state enum, TIMER_W default.
- Sub-module sal_dn_timer: loadable saturating down-counter with an expired flag. Three instances: tRCD, tRP, tRAS.

Test Plan:
- Open policy, config tRCD=3, tRP=3, tRAS=8, cmd_ready=1. Read row 0x12 col 0x40 id 5 -> ACT row 0x12 at T; RD col 0x40 id 5 at T+3; bank_open=1; open_row=0x12.
- Second read to row 0x12 col 0x44 -> RD only, no ACT, presented the cycle after buffer load.
- Then a write to row 0x34 -> PRE no earlier than first ACT+8; ACT 0x34 at PRE+3; WR at ACT+3.
- PAGE_POLICY=1, single read to row 0x12 -> ACT@T, RD@T+3, PRE@T+8; bank_open=0 after PRE.
- cmd_ready low for 5 cycles during a presented ACT -> cmd_valid stays high with cmd_type=1 and cmd_row constant; transfer occurs on cycle 6.
- ref_req raised with row open and buffer empty -> PRE, then ref_ack=1 after tRP. A request arriving during refresh gets no ACT until ref_req=0.
- rst asserted during ACT_WAIT -> next cycle cmd_valid=0, bank_open=0, req_ready=1, state IDLE.

Source files
------------

// File: rtl/sal_ddr_pkg.sv
// rtl/sal_ddr_pkg.sv - shared DDR2 bank types: command encodings, bank states, timer width
package sal_ddr_pkg;

    localparam int TIMER_W_DEF = 5;

    typedef enum logic [1:0] {
        CMD_PRE = 2'd0,
        CMD_ACT = 2'd1,
        CMD_RD  = 2'd2,
        CMD_WR  = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACT_WAIT = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_PRE_WAIT = 2'd3
    } bank_state_e;

endpackage

// File: rtl/sal_dn_timer.sv
// rtl/sal_dn_timer.sv - loadable saturating down-counter with expired flag
// Loading N makes expired rise exactly max(N,1) cycles after the load edge.
module sal_dn_timer
    import sal_ddr_pkg::*;
#(
    parameter int W = TIMER_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (value == '0) ? '0 : value - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/sal_bank_fsm.sv
// rtl/sal_bank_fsm.sv - per-bank DDR2 state machine issuing ACT/RD/WR/PRE requests
// Enforces tRCD/tRP/tRAS, open- or close-page policy, and parks the bank for refresh.
module sal_bank_fsm
    import sal_ddr_pkg::*;
#(
    parameter int ROW_W       = 14,
    parameter int COL_W       = 10,
    parameter int ID_W        = 4,
    parameter int TIMER_W     = TIMER_W_DEF,
    parameter int PAGE_POLICY = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [ROW_W-1:0]   req_row,
    input  logic [COL_W-1:0]   req_col,
    input  logic [ID_W-1:0]    req_id,
    input  logic [TIMER_W-1:0] cfg_trcd,
    input  logic [TIMER_W-1:0] cfg_trp,
    input  logic [TIMER_W-1:0] cfg_tras,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [1:0]         cmd_type,
    output logic [ROW_W-1:0]   cmd_row,
    output logic [COL_W-1:0]   cmd_col,
    output logic [ID_W-1:0]    cmd_id,
    input  logic               ref_req,
    output logic               ref_ack,
    output logic               bank_open,
    output logic [ROW_W-1:0]   open_row
);

    bank_state_e state_q, state_d;

    logic             buf_valid;
    logic             buf_wr;
    logic [ROW_W-1:0] buf_row;
    logic [COL_W-1:0] buf_col;
    logic [ID_W-1:0]  buf_id;

    logic             hold_valid;
    cmd_type_e        hold_type;
    logic [ROW_W-1:0] hold_row;
    logic [COL_W-1:0] hold_col;
    logic [ID_W-1:0]  hold_id;

    logic      fresh_valid;
    cmd_type_e fresh_type;
    cmd_type_e cmd_type_w;

    logic trcd_exp, trp_exp, tras_exp;
    logic cmd_hs, act_hs, pre_hs, rw_hs;
    logic closed_win, open_win, row_hit;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign act_hs = cmd_hs && (cmd_type_w == CMD_ACT);
    assign pre_hs = cmd_hs && (cmd_type_w == CMD_PRE);
    assign rw_hs  = cmd_hs && ((cmd_type_w == CMD_RD) || (cmd_type_w == CMD_WR));

    // The wait states behave like their target state in the cycle their timer
    // expires, so the dependent command lands exactly max(N,1) cycles later.
    assign closed_win = (state_q == ST_IDLE) || ((state_q == ST_PRE_WAIT) && trp_exp);
    assign open_win   = (state_q == ST_ACTIVE) || ((state_q == ST_ACT_WAIT) && trcd_exp);
    assign row_hit    = bank_open && (buf_row == open_row);

    sal_dn_timer #(.W(TIMER_W)) u_trcd (
        .clk     (clk),
        .rst     (rst),
        .load    (act_hs),
        .value   (cfg_trcd),
        .expired (trcd_exp)
    );

    sal_dn_timer #(.W(TIMER_W)) u_tras (
        .clk     (clk),
        .rst     (rst),
        .load    (act_hs),
        .value   (cfg_tras),
        .expired (tras_exp)
    );

    sal_dn_timer #(.W(TIMER_W)) u_trp (
        .clk     (clk),
        .rst     (rst),
        .load    (pre_hs),
        .value   (cfg_trp),
        .expired (trp_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (act_hs) state_d = ST_ACT_WAIT;
            end
            ST_ACT_WAIT: begin
                if (trcd_exp) state_d = pre_hs ? ST_PRE_WAIT : ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (pre_hs) state_d = ST_PRE_WAIT;
            end
            ST_PRE_WAIT: begin
                if (trp_exp) state_d = act_hs ? ST_ACT_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fresh_valid = 1'b0;
        fresh_type  = CMD_PRE;
        if (closed_win) begin
            if (buf_valid && !ref_req && trp_exp) begin
                fresh_valid = 1'b1;
                fresh_type  = CMD_ACT;
            end
        end else if (open_win) begin
            if (buf_valid && row_hit) begin
                fresh_valid = 1'b1;
                fresh_type  = buf_wr ? CMD_WR : CMD_RD;
            end else if ((buf_valid || ref_req || (PAGE_POLICY != 0)) && tras_exp) begin
                fresh_valid = 1'b1;
                fresh_type  = CMD_PRE;
            end
        end

        // A stalled command is replayed from the hold copy so it cannot change
        // when the buffer refills or ref_req moves before the grant.
        cmd_valid  = hold_valid || fresh_valid;
        cmd_type_w = hold_valid ? hold_type : fresh_type;
        cmd_row    = hold_valid ? hold_row  : buf_row;
        cmd_col    = hold_valid ? hold_col  : buf_col;
        cmd_id     = hold_valid ? hold_id   : buf_id;
        cmd_type   = cmd_type_w;
        req_ready  = !buf_valid;
        ref_ack    = (state_q == ST_IDLE) && ref_req && !cmd_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_type  <= CMD_PRE;
            hold_row   <= '0;
            hold_col   <= '0;
            hold_id    <= '0;
        end else if (cmd_valid && !cmd_ready) begin
            hold_valid <= 1'b1;
            hold_type  <= cmd_type_w;
            hold_row   <= cmd_row;
            hold_col   <= cmd_col;
            hold_id    <= cmd_id;
        end else begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_wr    <= 1'b0;
            buf_row   <= '0;
            buf_col   <= '0;
            buf_id    <= '0;
        end else if (rw_hs) begin
            buf_valid <= 1'b0;
        end else if (req_valid && !buf_valid) begin
            buf_valid <= 1'b1;
            buf_wr    <= req_wr;
            buf_row   <= req_row;
            buf_col   <= req_col;
            buf_id    <= req_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open <= 1'b0;
            open_row  <= '0;
        end else if (act_hs) begin
            bank_open <= 1'b1;
            open_row  <= cmd_row;
        end else if (pre_hs) begin
            bank_open <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sal_bank_fsm.sv
// tb/tb_sal_bank_fsm.sv - directed self-checking bench for sal_bank_fsm (open and close page)
module tb_sal_bank_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_wr, cmd_ready, ref_req;
    logic [13:0] req_row;
    logic [9:0]  req_col;
    logic [3:0]  req_id;
    logic [4:0]  cfg_trcd, cfg_trp, cfg_tras;

    logic        o_req_ready, o_cmd_valid, o_ref_ack, o_bank_open;
    logic [1:0]  o_cmd_type;
    logic [13:0] o_cmd_row, o_open_row;
    logic [9:0]  o_cmd_col;
    logic [3:0]  o_cmd_id;

    logic        c_req_ready, c_cmd_valid, c_ref_ack, c_bank_open;
    logic [1:0]  c_cmd_type;
    logic [13:0] c_cmd_row, c_open_row;
    logic [9:0]  c_cmd_col;
    logic [3:0]  c_cmd_id;

    sal_bank_fsm #(.PAGE_POLICY(0)) dut_open (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_req_ready),
        .req_wr(req_wr), .req_row(req_row), .req_col(req_col), .req_id(req_id),
        .cfg_trcd(cfg_trcd), .cfg_trp(cfg_trp), .cfg_tras(cfg_tras),
        .cmd_valid(o_cmd_valid), .cmd_ready(cmd_ready), .cmd_type(o_cmd_type),
        .cmd_row(o_cmd_row), .cmd_col(o_cmd_col), .cmd_id(o_cmd_id),
        .ref_req(ref_req), .ref_ack(o_ref_ack), .bank_open(o_bank_open), .open_row(o_open_row)
    );

    sal_bank_fsm #(.PAGE_POLICY(1)) dut_close (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(c_req_ready),
        .req_wr(req_wr), .req_row(req_row), .req_col(req_col), .req_id(req_id),
        .cfg_trcd(cfg_trcd), .cfg_trp(cfg_trp), .cfg_tras(cfg_tras),
        .cmd_valid(c_cmd_valid), .cmd_ready(cmd_ready), .cmd_type(c_cmd_type),
        .cmd_row(c_cmd_row), .cmd_col(c_cmd_col), .cmd_id(c_cmd_id),
        .ref_req(ref_req), .ref_ack(c_ref_ack), .bank_open(c_bank_open), .open_row(c_open_row)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    int          hs_t;
    logic [1:0]  hs_type;
    logic [13:0] hs_row;
    logic [9:0]  hs_col;
    logic [3:0]  hs_id;
    int          tl, t_act;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] trcd, input logic [4:0] trp, input logic [4:0] tras);
        cfg_trcd = trcd; cfg_trp = trp; cfg_tras = tras;
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
        req_row = '0; req_col = '0; req_id = '0;
        ref_req = 1'b0; cmd_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_req(input logic wr, input logic [13:0] row, input logic [9:0] col,
                            input logic [3:0] id);
        req_wr = wr; req_row = row; req_col = col; req_id = id;
        req_valid = 1'b1;
        tl = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    // Records the next handshake of the selected DUT; hs_t stays -1 on timeout.
    task automatic wait_hs(input bit sel, input int budget);
        bit done;
        done = 1'b0;
        hs_t = -1; hs_type = '0; hs_row = '0; hs_col = '0; hs_id = '0;
        for (int i = 0; i < budget && !done; i++) begin
            #1;
            if (sel ? (c_cmd_valid && cmd_ready) : (o_cmd_valid && cmd_ready)) begin
                done    = 1'b1;
                hs_t    = cyc;
                hs_type = sel ? c_cmd_type : o_cmd_type;
                hs_row  = sel ? c_cmd_row : o_cmd_row;
                hs_col  = sel ? c_cmd_col : o_cmd_col;
                hs_id   = sel ? c_cmd_id : o_cmd_id;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset(5'd3, 5'd3, 5'd8);
        #1;
        checks++; if (o_cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_cmd_valid got=%b exp=0", o_cmd_valid); end
        checks++; if (o_cmd_type !== 2'd0) begin failures++; $display("FAIL rst_cmd_type got=%0d exp=0", o_cmd_type); end
        checks++; if ({o_cmd_row, o_cmd_col, o_cmd_id} !== 28'd0) begin failures++; $display("FAIL rst_cmd_fields got=%h/%h/%h exp=0", o_cmd_row, o_cmd_col, o_cmd_id); end
        checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", o_req_ready); end
        checks++; if (o_ref_ack !== 1'b0) begin failures++; $display("FAIL rst_ref_ack got=%b exp=0", o_ref_ack); end
        checks++; if (o_bank_open !== 1'b0) begin failures++; $display("FAIL rst_bank_open got=%b exp=0", o_bank_open); end
        checks++; if (o_open_row !== 14'd0) begin failures++; $display("FAIL rst_open_row got=%h exp=0", o_open_row); end
        checks++; if ({c_cmd_valid, c_req_ready, c_bank_open} !== 3'b010) begin failures++; $display("FAIL rst_close_dut got=%b exp=010", {c_cmd_valid, c_req_ready, c_bank_open}); end
        tick();
    endtask

    task automatic test_open_read();
        do_reset(5'd3, 5'd3, 5'd8);
        load_req(1'b0, 14'h12, 10'h40, 4'd5);
        wait_hs(1'b0, 20);
        checks++; if (hs_t !== tl + 1) begin failures++; $display("FAIL rd1_act_time got=%0d exp=%0d", hs_t, tl + 1); end
        checks++; if ({hs_type, hs_row} !== {2'd1, 14'h12}) begin failures++; $display("FAIL rd1_act_cmd got=%0d/%h exp=1/12", hs_type, hs_row); end
        t_act = hs_t;
        wait_hs(1'b0, 20);
        checks++; if (hs_t !== t_act + 3) begin failures++; $display("FAIL rd1_rd_time got=%0d exp=%0d", hs_t, t_act + 3); end
        checks++; if ({hs_type, hs_col, hs_id} !== {2'd2, 10'h40, 4'd5}) begin failures++; $display("FAIL rd1_rd_cmd got=%0d/%h/%0d exp=2/40/5", hs_type, hs_col, hs_id); end
        checks++; if ({o_bank_open, o_open_row} !== {1'b1, 14'h12}) begin failures++; $display("FAIL rd1_open got=%b/%h exp=1/12", o_bank_open, o_open_row); end
    endtask

    task automatic test_page_hit();
        load_req(1'b0, 14'h12, 10'h44, 4'd6);
        wait_hs(1'b0, 20);
        checks++; if (hs_t !== tl + 1) begin failures++; $display("FAIL hit_time got=%0d exp=%0d", hs_t, tl + 1); end
        checks++; if ({hs_type, hs_col, hs_id} !== {2'd2, 10'h44, 4'd6}) begin failures++; $display("FAIL hit_cmd got=%0d/%h/%0d exp=2/44/6", hs_type, hs_col, hs_id); end
    endtask

    task automatic test_page_miss();
        int exp_pre, tp, ta;
        load_req(1'b1, 14'h34, 10'h10, 4'd7);
        exp_pre = (t_act + 8 > tl + 1) ? t_act + 8 : tl + 1;
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type} !== {exp_pre, 2'd0}) begin failures++; $display("FAIL miss_pre got=t%0d/%0d exp=t%0d/0", hs_t, hs_type, exp_pre); end
        tp = hs_t;
        checks++; if (o_bank_open !== 1'b0) begin failures++; $display("FAIL miss_closed got=%b exp=0", o_bank_open); end
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type, hs_row} !== {tp + 3, 2'd1, 14'h34}) begin failures++; $display("FAIL miss_act got=t%0d/%0d/%h exp=t%0d/1/34", hs_t, hs_type, hs_row, tp + 3); end
        ta = hs_t;
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type, hs_col, hs_id} !== {ta + 3, 2'd3, 10'h10, 4'd7}) begin failures++; $display("FAIL miss_wr got=t%0d/%0d/%h/%0d exp=t%0d/3/10/7", hs_t, hs_type, hs_col, hs_id, ta + 3); end
    endtask

    task automatic test_close_policy();
        int ta;
        do_reset(5'd3, 5'd3, 5'd8);
        load_req(1'b0, 14'h12, 10'h20, 4'd2);
        wait_hs(1'b1, 20);
        checks++; if ({hs_t, hs_type, hs_row} !== {tl + 1, 2'd1, 14'h12}) begin failures++; $display("FAIL cp_act got=t%0d/%0d/%h exp=t%0d/1/12", hs_t, hs_type, hs_row, tl + 1); end
        ta = hs_t;
        wait_hs(1'b1, 20);
        checks++; if ({hs_t, hs_type} !== {ta + 3, 2'd2}) begin failures++; $display("FAIL cp_rd got=t%0d/%0d exp=t%0d/2", hs_t, hs_type, ta + 3); end
        wait_hs(1'b1, 20);
        checks++; if ({hs_t, hs_type} !== {ta + 8, 2'd0}) begin failures++; $display("FAIL cp_pre got=t%0d/%0d exp=t%0d/0", hs_t, hs_type, ta + 8); end
        checks++; if (c_bank_open !== 1'b0) begin failures++; $display("FAIL cp_closed got=%b exp=0", c_bank_open); end
    endtask

    task automatic test_backpressure();
        int t0;
        do_reset(5'd3, 5'd3, 5'd8);
        cmd_ready = 1'b0;
        load_req(1'b0, 14'h55, 10'h01, 4'd3);
        t0 = cyc;
        for (int k = 0; k < 5; k++) begin
            if (k >= 2) ref_req = 1'b1;
            #1;
            checks++; if ({o_cmd_valid, o_cmd_type, o_cmd_row} !== {1'b1, 2'd1, 14'h55}) begin failures++; $display("FAIL bp_hold%0d got=%b/%0d/%h exp=1/1/55", k, o_cmd_valid, o_cmd_type, o_cmd_row); end
            tick();
        end
        cmd_ready = 1'b1;
        wait_hs(1'b0, 5);
        checks++; if ({hs_t, hs_type, hs_row} !== {t0 + 5, 2'd1, 14'h55}) begin failures++; $display("FAIL bp_xfer got=t%0d/%0d/%h exp=t%0d/1/55", hs_t, hs_type, hs_row, t0 + 5); end
        t_act = hs_t;
        ref_req = 1'b0;
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type} !== {t_act + 3, 2'd2}) begin failures++; $display("FAIL bp_rd got=t%0d/%0d exp=t%0d/2", hs_t, hs_type, t_act + 3); end
    endtask

    task automatic test_refresh();
        int exp_pre, tp, tr;
        ref_req = 1'b1;
        exp_pre = (cyc > t_act + 8) ? cyc : t_act + 8;
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type} !== {exp_pre, 2'd0}) begin failures++; $display("FAIL ref_pre got=t%0d/%0d exp=t%0d/0", hs_t, hs_type, exp_pre); end
        tp = hs_t;
        checks++; if (o_bank_open !== 1'b0) begin failures++; $display("FAIL ref_closed got=%b exp=0", o_bank_open); end
        tick(); tick(); tick();
        checks++; if (o_ref_ack !== 1'b1) begin failures++; $display("FAIL ref_ack_t%0d got=%b exp=1", tp + 4, o_ref_ack); end
        load_req(1'b0, 14'h66, 10'h05, 4'd8);
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if ({o_cmd_valid, o_ref_ack} !== 2'b01) begin failures++; $display("FAIL ref_park%0d got=%b/%b exp=0/1", k, o_cmd_valid, o_ref_ack); end
            tick();
        end
        ref_req = 1'b0;
        tr = cyc;
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type, hs_row} !== {tr, 2'd1, 14'h66}) begin failures++; $display("FAIL ref_resume got=t%0d/%0d/%h exp=t%0d/1/66", hs_t, hs_type, hs_row, tr); end
        wait_hs(1'b0, 20);
    endtask

    task automatic test_reset_mid();
        do_reset(5'd3, 5'd3, 5'd8);
        load_req(1'b0, 14'h77, 10'h07, 4'd1);
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type, o_bank_open} !== {tl + 1, 2'd1, 1'b1}) begin failures++; $display("FAIL rm_act got=t%0d/%0d/%b exp=t%0d/1/1", hs_t, hs_type, o_bank_open, tl + 1); end
        rst = 1'b1;
        tick();
        checks++; if ({o_cmd_valid, o_bank_open, o_req_ready} !== 3'b001) begin failures++; $display("FAIL rm_state got=%b exp=001", {o_cmd_valid, o_bank_open, o_req_ready}); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if ({o_cmd_valid, o_ref_ack, o_bank_open} !== 3'b000) begin failures++; $display("FAIL rm_idle%0d got=%b exp=000", k, {o_cmd_valid, o_ref_ack, o_bank_open}); end
            tick();
        end
    endtask

    task automatic test_zero_cfg();
        int ta, tp;
        do_reset(5'd0, 5'd0, 5'd0);
        load_req(1'b0, 14'h01, 10'h02, 4'd9);
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type} !== {tl + 1, 2'd1}) begin failures++; $display("FAIL z_act got=t%0d/%0d exp=t%0d/1", hs_t, hs_type, tl + 1); end
        ta = hs_t;
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type, hs_id} !== {ta + 1, 2'd2, 4'd9}) begin failures++; $display("FAIL z_rd got=t%0d/%0d/%0d exp=t%0d/2/9", hs_t, hs_type, hs_id, ta + 1); end
        load_req(1'b1, 14'h02, 10'h03, 4'd10);
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type} !== {tl + 1, 2'd0}) begin failures++; $display("FAIL z_pre got=t%0d/%0d exp=t%0d/0", hs_t, hs_type, tl + 1); end
        tp = hs_t;
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type, hs_row} !== {tp + 1, 2'd1, 14'h02}) begin failures++; $display("FAIL z_act2 got=t%0d/%0d/%h exp=t%0d/1/2", hs_t, hs_type, hs_row, tp + 1); end
        ta = hs_t;
        wait_hs(1'b0, 20);
        checks++; if ({hs_t, hs_type, hs_col} !== {ta + 1, 2'd3, 10'h03}) begin failures++; $display("FAIL z_wr got=t%0d/%0d/%h exp=t%0d/3/3", hs_t, hs_type, hs_col, ta + 1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_open_read();
        test_page_hit();
        test_page_miss();
        test_close_policy();
        test_backpressure();
        test_refresh();
        test_reset_mid();
        test_zero_cfg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
